// File: rtl/rns_mod_accum.sv
// Modulo-(2^W-1) streaming accumulator: sums one residue per accepted beat with
// end-around carry and emits one normalized residue plus beat count per frame.
module rns_mod_accum #(
    parameter int W     = 6,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [CNT_W-1:0] out_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    localparam logic [W-1:0]     ONES    = '1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_reg, state_next;
    logic [W-1:0]     acc_reg, acc_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic [W-1:0]     out_data_reg;
    logic [CNT_W-1:0] out_count_reg;

    logic             accept;
    logic [W-1:0]     x;
    logic [W:0]       carry;
    logic [W-1:0]     psum;
    logic [W-1:0]     wrapped;
    logic [W-1:0]     sum_norm;
    logic [CNT_W-1:0] cnt_inc;

    assign in_ready  = (state_reg != HOLD);
    assign accept    = in_valid & in_ready;
    assign out_valid = (state_reg == HOLD);
    assign out_data  = out_data_reg;
    assign out_count = out_count_reg;

    // All-ones is the second encoding of zero in a one's-complement residue.
    assign x = (in_data == ONES) ? '0 : in_data;

    // Ripple adder; carry[W] is the carry folded back in as the end-around carry.
    assign carry[0] = 1'b0;
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_add
            assign psum[gi]      = acc_reg[gi] ^ x[gi] ^ carry[gi];
            assign carry[gi + 1] = (acc_reg[gi] & x[gi]) | (carry[gi] & (acc_reg[gi] ^ x[gi]));
        end
    endgenerate

    // Both operands are at most M-1, so folding the carry back cannot overflow.
    assign wrapped  = psum + W'(carry[W]);
    assign sum_norm = (wrapped == ONES) ? '0 : wrapped;
    assign cnt_inc  = (cnt_reg == CNT_MAX) ? CNT_MAX : cnt_reg + 1'b1;

    always_comb begin
        state_next = state_reg;
        acc_next   = acc_reg;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                acc_next = '0;
                cnt_next = '0;
                if (accept) begin
                    acc_next   = sum_norm;
                    cnt_next   = cnt_inc;
                    state_next = in_last ? HOLD : ACC;
                end
            end
            ACC: begin
                if (accept) begin
                    acc_next   = sum_norm;
                    cnt_next   = cnt_inc;
                    state_next = in_last ? HOLD : ACC;
                end
            end
            HOLD: begin
                if (out_ready) begin
                    acc_next   = '0;
                    cnt_next   = '0;
                    state_next = IDLE;
                end
            end
            default: begin
                acc_next   = '0;
                cnt_next   = '0;
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            acc_reg       <= '0;
            cnt_reg       <= '0;
            out_data_reg  <= '0;
            out_count_reg <= '0;
        end else begin
            state_reg <= state_next;
            acc_reg   <= acc_next;
            cnt_reg   <= cnt_next;
            // Result is captured on the same edge that accepts the closing beat.
            if (accept && in_last) begin
                out_data_reg  <= sum_norm;
                out_count_reg <= cnt_inc;
            end
        end
    end

endmodule

// File: doc/rns_mod_accum.md
Name: rns_mod_accum

Overview:
Sequential modulo-(2^W - 1) accumulator for the RNS datapath. It takes a stream of residues over a valid/ready handshake and sums them one operand per cycle. The sum is reduced with end-around carry, the same reduction the 6-bit CLA stage applies to its cout. One normalized residue is emitted per frame, where a frame ends on the beat carrying in_last.

Parameters:
W, 6, residue width; modulus M = 2^W - 1 (63 by default)
CNT_W, 8, width of the operand counter; the counter saturates at 2^CNT_W - 1

Ports:
clk  input  1  clock; all logic rising-edge
rst  input  1  synchronous, active-high reset
in_valid  input  1  input beat valid
in_ready  output  1  block accepts a beat this cycle
in_data  input  W  residue operand; all-ones is treated as 0
in_last  input  1  qualifies the final beat of a frame
out_valid  output  1  result valid
out_ready  input  1  downstream accepts the result
out_data  output  W  frame sum mod M, normalized to 0..M-1
out_count  output  CNT_W  number of beats accepted in the frame (saturating)

Behaviour:
- Clock and reset:
  - One clock, clk. Reset is synchronous and active-high on rst.
  - While rst=1 at a clock edge: state goes to IDLE, acc=0, cnt=0, out_valid=0, out_data=0, out_count=0.
  - in_ready=1 in the first cycle after reset.
  - Reset mid-frame or while out_valid=1 discards all partial and held data with no output.
- States: IDLE, ACC, HOLD.
  - in_ready = 1 in IDLE and ACC; in_ready = 0 in HOLD (combinational from state).
  - Accept = in_valid & in_ready.
  - IDLE: on accept with in_last=0 -> ACC. On accept with in_last=1 -> HOLD. No accept -> stay; acc=0, cnt=0.
  - ACC: on accept with in_last=0 -> stay. On accept with in_last=1 -> HOLD. No accept (bubble) -> hold acc and cnt.
  - HOLD: out_valid=1; out_data and out_count are stable. On out_valid & out_ready -> IDLE with acc=0, cnt=0.
  - in_ready returns high the cycle after the handshake; there is no same-cycle overlap of output handshake and input accept.
- Arithmetic, per accept:
  - x = (in_data == all-ones) ? 0 : in_data.
  - {c, s} = acc + x, a (W+1)-bit sum.
  - r = s + c (end-around carry); this cannot carry again because acc and x are each <= M-1.
  - acc_next = (r == all-ones) ? 0 : r.
- Counter: cnt_next = (cnt == max) ? max : cnt + 1.
- Output latency: 1 cycle. out_valid rises on the edge that accepts the last beat. out_data = acc_next and out_count = cnt_next of that beat, both registered.
- The accumulator register always holds a value in 0..M-1; M never appears on out_data.
- in_last is ignored when in_valid=0.
- out_ready is ignored outside HOLD.

Test Plan:
1. Reset: assert rst for 2 cycles with in_valid=1 -> out_valid=0, out_data=0, out_count=0; in_ready=1 on the first cycle after reset.
2. Frame 10, 20, 30 (last), out_ready=1 -> out_valid for exactly 1 cycle; out_data=60, out_count=3; that cycle is the one after the accept of 30.
3. End-around carry: frame 40, 30 (last) -> 70 = 64 + 6, so out_data=7, out_count=2.
4. Normalization:
   - Frame 31, 32 (last) -> out_data=0.
   - Single-beat frame 63 (last) -> out_data=0.
   - Single-beat frame 62 (last) -> out_data=62, out_count=1.
5. Backpressure and bubbles:
   - Frame 5, bubble, bubble, 9 (last) -> out_data=14, out_count=2.
   - Hold out_ready=0 for 5 cycles with in_valid=1 -> in_ready=0 and out_data/out_count stable throughout.
   - Raise out_ready -> IDLE; the next frame starts from acc=0.
6. Reset mid-frame: accept 50, 60, then rst=1 for one cycle, then frame 1 (last) -> out_data=1, out_count=1; no output is produced for the aborted frame.
   - Counter saturation (CNT_W=2): 5-beat frame of 1s -> out_count=3, out_data=5.
